// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the execute stage and the
// multi-cycle multiply/divide unit.
interface alu_muldiv_seq_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 5
);
    logic              start;
    logic [CTRL_W-1:0] op;
    logic [WIDTH-1:0]  src_a;
    logic [WIDTH-1:0]  src_b;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;
    logic              busy;
    logic              done;
    logic              div_zero;

    modport master (
        output start, op, src_a, src_b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, src_a, src_b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide unit with HI/LO registers: one bit per
// cycle for WIDTH cycles, then a single sign fix-up/write cycle.
module alu_muldiv_seq #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    alu_muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [CTRL_W-1:0] OP_DIV   = CTRL_W'(5'b00100);
    localparam logic [CTRL_W-1:0] OP_MULT  = CTRL_W'(5'b01001);
    localparam logic [CTRL_W-1:0] OP_MULTU = CTRL_W'(5'b01010);
    localparam logic [CTRL_W-1:0] OP_DIVU  = CTRL_W'(5'b01011);
    localparam logic [CTRL_W-1:0] OP_MTHI  = CTRL_W'(5'b10100);
    localparam logic [CTRL_W-1:0] OP_MTLO  = CTRL_W'(5'b10101);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     p_q, p_d;
    logic [WIDTH-1:0]       m_q, m_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   div_q, div_d;
    logic                   neg_q, neg_d;
    logic                   rneg_q, rneg_d;
    logic                   bz_q, bz_d;
    logic                   done_q, done_d;
    logic                   dz_q, dz_d;

    logic                   is_mul, is_div, is_sgn, accept;
    logic                   sa, sb;
    logic [WIDTH-1:0]       mag_a, mag_b;
    logic [WIDTH:0]         msum, diff;
    logic [2*WIDTH-1:0]     mstep, dstep, prod;
    logic [WIDTH-1:0]       quo, rem;

    always_comb begin
        is_mul = (bus.op == OP_MULT) | (bus.op == OP_MULTU);
        is_div = (bus.op == OP_DIV)  | (bus.op == OP_DIVU);
        is_sgn = (bus.op == OP_MULT) | (bus.op == OP_DIV);
        accept = bus.start & (state_q == IDLE) & (is_mul | is_div);
        sa     = is_sgn & bus.src_a[WIDTH-1];
        sb     = is_sgn & bus.src_b[WIDTH-1];
        // The most-negative value maps onto 2^(WIDTH-1) as an unsigned magnitude
        mag_a  = sa ? -bus.src_a : bus.src_a;
        mag_b  = sb ? -bus.src_b : bus.src_b;
    end

    // p holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        msum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        mstep = {msum, p_q[WIDTH-1:1]};
        diff  = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
        dstep = diff[WIDTH] ? {p_q[2*WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        prod  = neg_q  ? -p_q : p_q;
        quo   = neg_q  ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        rem   = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        p_d    = p_q;
        m_d    = m_q;
        a_d    = a_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        div_d  = div_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        bz_d   = bz_q;
        dz_d   = dz_q;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d  = '0;
                    p_d    = {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
                    m_d    = is_div ? mag_b : mag_a;
                    a_d    = bus.src_a;
                    div_d  = is_div;
                    neg_d  = sa ^ sb;
                    rneg_d = sa;
                    bz_d   = (bus.src_b == '0);
                    dz_d   = 1'b0;
                end else if (bus.start) begin
                    unique case (1'b1)
                        (bus.op == OP_MTHI): hi_d = bus.src_a;
                        (bus.op == OP_MTLO): lo_d = bus.src_a;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                p_d   = div_q ? dstep : mstep;
            end
            FIX: begin
                done_d = 1'b1;
                if (div_q && bz_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                    dz_d = 1'b1;
                end else if (div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            m_q     <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            bz_q    <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            m_q     <= m_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            bz_q    <= bz_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        bus.busy     = (state_q != IDLE);
        bus.done     = done_q;
        bus.div_zero = dz_q;
        bus.hi       = hi_q;
        bus.lo       = lo_q;
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed plus randomized checks of alu_muldiv_seq against an
// arithmetic reference model of HI/LO and div_zero.
module tb_alu_muldiv_seq;
    localparam logic [4:0] DIV   = 5'b00100;
    localparam logic [4:0] MULT  = 5'b01001;
    localparam logic [4:0] MULTU = 5'b01010;
    localparam logic [4:0] DIVU  = 5'b01011;
    localparam logic [4:0] MTHI  = 5'b10100;
    localparam logic [4:0] MTLO  = 5'b10101;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_hi, m_lo;
    logic        m_dz;

    alu_muldiv_seq_if #(.WIDTH(32), .CTRL_W(5)) bus ();

    alu_muldiv_seq #(.WIDTH(32), .CTRL_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_md(input logic [4:0] o);
        return o == MULT || o == MULTU || o == DIV || o == DIVU;
    endfunction

    // Reference results from plain 64-bit integer arithmetic
    task automatic model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ed = 1'b0;
        eh = 32'h0;
        el = 32'h0;
        if (o == MULT) begin
            p = 64'(sa * sb);
            eh = p[63:32]; el = p[31:0];
        end else if (o == MULTU) begin
            p = {32'h0, a} * {32'h0, b};
            eh = p[63:32]; el = p[31:0];
        end else if (b == 32'h0) begin
            eh = a; el = 32'hFFFF_FFFF; ed = 1'b1;
        end else if (o == DIV) begin
            q = sa / sb;
            r = sa % sb;
            el = q[31:0]; eh = r[31:0];
        end else begin
            el = a / b; eh = a % b;
        end
    endtask

    task automatic run_md(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, input logic [4:0] io, input logic [31:0] ia);
        logic [31:0] eh, el, oh, ol;
        logic        ed, hold_bad;
        int          n, bcnt;
        model(o, a, b, eh, el, ed);
        oh = m_hi;
        ol = m_lo;
        hold_bad = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        chk("busy_at_accept", 64'(bus.busy), 64'd1);
        chk("done_at_accept", 64'(bus.done), 64'd0);
        chk("dz_cleared", 64'(bus.div_zero), 64'd0);
        n = 0;
        bcnt = 1;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            if (n == inj_at) begin
                bus.start = 1'b1; bus.op = io; bus.src_a = ia;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n++;
            if (bus.busy) bcnt++;
            if (!bus.done && (bus.hi !== oh || bus.lo !== ol)) hold_bad = 1'b1;
        end
        chk("latency", 64'(n), 64'd33);
        chk("busy_cycles", 64'(bcnt), 64'd33);
        chk("hold_during_calc", 64'(hold_bad), 64'd0);
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        chk("hi", 64'(bus.hi), 64'(eh));
        chk("lo", 64'(bus.lo), 64'(el));
        chk("div_zero", 64'(bus.div_zero), 64'(ed));
        m_hi = eh;
        m_lo = el;
        m_dz = ed;
    endtask

    task automatic run_single(input logic [4:0] o, input logic [31:0] a);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = $urandom;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (o == MTHI) m_hi = a;
        if (o == MTLO) m_lo = a;
        chk("single_hi", 64'(bus.hi), 64'(m_hi));
        chk("single_lo", 64'(bus.lo), 64'(m_lo));
        chk("single_busy", 64'(bus.busy), 64'd0);
        chk("single_done", 64'(bus.done), 64'd0);
        chk("single_dz", 64'(bus.div_zero), 64'(m_dz));
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] sp [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        int k;
        k = int'($urandom_range(0, 8));
        if (k < 5) return sp[k];
        return $urandom;
    endfunction

    initial begin
        logic [4:0]  ops [4] = '{MULT, MULTU, DIV, DIVU};
        logic [4:0]  o;
        logic [31:0] a, b;
        int          kind, seen_done;

        bus.start = 1'b0; bus.op = 5'h0; bus.src_a = 32'h0; bus.src_b = 32'h0;
        reset = 1'b1;
        m_hi = 32'h0; m_lo = 32'h0; m_dz = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dz", 64'(bus.div_zero), 64'd0);

        run_md(MULT,  32'hFFFF_FFFD, 32'd5, -1, 5'h0, 32'h0);
        chk("mult_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("mult_neg_lo", 64'(bus.lo), 64'hFFFF_FFF1);
        run_md(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 5'h0, 32'h0);
        chk("multu_max_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        run_md(MULT,  32'h8000_0000, 32'h8000_0000, -1, 5'h0, 32'h0);
        chk("mult_min_hi", 64'(bus.hi), 64'h4000_0000);
        run_md(DIV,   32'hFFFF_FFF9, 32'd2, -1, 5'h0, 32'h0);
        chk("div_neg_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        run_md(DIV,   32'd7, 32'hFFFF_FFFE, -1, 5'h0, 32'h0);
        chk("div_negb_hi", 64'(bus.hi), 64'd1);
        run_md(DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, 5'h0, 32'h0);
        chk("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
        run_md(DIVU,  32'd7, 32'd0, -1, 5'h0, 32'h0);
        chk("divu_zero_flag", 64'(bus.div_zero), 64'd1);
        run_md(DIVU,  32'd9, 32'd4, -1, 5'h0, 32'h0);
        chk("divu_9_4_lo", 64'(bus.lo), 64'd2);
        run_md(MULT,  32'd6, 32'd7, 3, MTLO, 32'h1234);
        chk("mtlo_ignored_lo", 64'(bus.lo), 64'd42);
        run_md(MULTU, 32'd3, 32'd3, 10, DIVU, 32'd99);
        run_single(MTHI, 32'hABCD);
        run_single(5'b00000, 32'hDEAD_BEEF);

        // Abort an in-flight divide with reset
        @(negedge clk);
        bus.start = 1'b1; bus.op = DIVU; bus.src_a = 32'd100; bus.src_b = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0; m_dz = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen_done++;
        end
        chk("abort_no_result", 64'(seen_done), 64'd0);
        run_md(DIVU, 32'd100, 32'd3, -1, 5'h0, 32'h0);
        chk("divu_100_3_lo", 64'(bus.lo), 64'd33);

        for (int i = 0; i < 30; i++) begin
            kind = int'($urandom_range(0, 9));
            a = pick_operand();
            b = pick_operand();
            o = ops[$urandom_range(0, 3)];
            if (kind <= 5) begin
                run_md(o, a, b, int'($urandom_range(0, 45)), ops[$urandom_range(0, 3)], $urandom);
            end else if (kind == 6) begin
                run_single(MTHI, a);
            end else if (kind == 7) begin
                run_single(MTLO, a);
            end else if (kind == 8) begin
                o = 5'($urandom);
                while (is_md(o) || o == MTHI || o == MTLO) o = 5'($urandom);
                run_single(o, a);
            end else begin
                run_md(o, a, 32'h0, -1, 5'h0, 32'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
